// File: rtl/serial_add_ctrl.sv
// Bit-serial adder controller: one registered full-adder cell walks the operand bits LSB first.
// Optional SERIAL_ADD_OVF_EN adds a signed-overflow output alongside sum/cout.
module serial_add_ctrl #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             busy
`ifdef SERIAL_ADD_OVF_EN
    ,
    output logic             ovf
`endif
);

    localparam int IW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [IW-1:0] LAST_IDX = IW'(WIDTH - 1);

    localparam logic [2:0] IDLE    = 3'd0;
    localparam logic [2:0] ISSUE   = 3'd1;
    localparam logic [2:0] WAIT    = 3'd2;
    localparam logic [2:0] CAPTURE = 3'd3;
    localparam logic [2:0] DONE    = 3'd4;

    logic [2:0]       state_q, state_d;
    logic [IW-1:0]    idx_q;
    logic [WIDTH-1:0] a_q, b_q, sum_q, sum_r;
    logic             carry_q, cout_r;

    // Full-adder cell: stage 1 registers the inputs, stage 2 registers S/Co.
    logic cell_a, cell_b, cell_ci;
    logic s1_a, s1_b, s1_ci;
    logic cell_s, cell_co;

`ifdef SERIAL_ADD_OVF_EN
    logic ovf_r;
    assign ovf = ovf_r;
`endif

    assign in_ready  = (state_q == IDLE);
    assign out_valid = (state_q == DONE);
    assign busy      = (state_q != IDLE);
    assign sum       = sum_r;
    assign cout      = cout_r;

    // NOTE: every always_comb output gets a default first so no latch is inferred.
    always_comb begin
        state_d = state_q;
        cell_a  = 1'b0;
        cell_b  = 1'b0;
        cell_ci = 1'b0;
        case (state_q)
            IDLE:    if (in_valid) state_d = ISSUE;
            ISSUE: begin
                cell_a  = a_q[idx_q];
                cell_b  = b_q[idx_q];
                cell_ci = carry_q;
                state_d = WAIT;
            end
            WAIT:    state_d = CAPTURE;
            CAPTURE: state_d = (idx_q == LAST_IDX) ? DONE : ISSUE;
            DONE:    if (out_ready) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so all registers see pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            idx_q   <= '0;
            a_q     <= '0;
            b_q     <= '0;
            carry_q <= 1'b0;
            sum_q   <= '0;
            sum_r   <= '0;
            cout_r  <= 1'b0;
            s1_a    <= 1'b0;
            s1_b    <= 1'b0;
            s1_ci   <= 1'b0;
            cell_s  <= 1'b0;
            cell_co <= 1'b0;
`ifdef SERIAL_ADD_OVF_EN
            ovf_r   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            s1_a    <= cell_a;
            s1_b    <= cell_b;
            s1_ci   <= cell_ci;
            cell_s  <= s1_a ^ s1_b ^ s1_ci;
            cell_co <= (s1_a & s1_b) | (s1_a & s1_ci) | (s1_b & s1_ci);

            case (state_q)
                IDLE: begin
                    if (in_valid) begin
                        a_q     <= a;
                        b_q     <= b;
                        carry_q <= cin;
                        idx_q   <= '0;
                    end
                end
                CAPTURE: begin
                    sum_q[idx_q] <= cell_s;
                    carry_q      <= cell_co;
                    if (idx_q == LAST_IDX) begin
                        // carry_q still holds the carry into the MSB here.
                        sum_r  <= {cell_s, sum_q[WIDTH-2:0]};
                        cout_r <= cell_co;
`ifdef SERIAL_ADD_OVF_EN
                        ovf_r  <= carry_q ^ cell_co;
`endif
                    end else begin
                        idx_q <= idx_q + IW'(1);
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_serial_add_ctrl.sv
// Self-checking bench for serial_add_ctrl: directed and random operations against an arithmetic model.
// Define SERIAL_ADD_OVF_EN to also exercise the ovf output.
module tb_serial_add_ctrl;

    localparam int W   = 8;
    localparam int LAT = 3 * W + 1;

    logic         clk = 1'b0;
    logic         rst;
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] a, b;
    logic         cin;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] sum;
    logic         cout;
    logic         busy;
`ifdef SERIAL_ADD_OVF_EN
    logic         ovf;
`endif

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    serial_add_ctrl #(.WIDTH(W)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .cin       (cin),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .sum       (sum),
        .cout      (cout),
        .busy      (busy)
`ifdef SERIAL_ADD_OVF_EN
        ,
        .ovf       (ovf)
`endif
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Reference: plain (W+1)-bit addition; signed overflow from operand/result signs.
    function automatic logic [W:0] model_add(input logic [W-1:0] av, bv, input logic cv);
        return {1'b0, av} + {1'b0, bv} + {{W{1'b0}}, cv};
    endfunction

    function automatic logic model_ovf(input logic [W-1:0] av, bv, input logic cv);
        logic [W:0] r;
        r = model_add(av, bv, cv);
        return (av[W-1] == bv[W-1]) && (r[W-1] != av[W-1]);
    endfunction

    // Starts and ends on a negedge with the DUT idle.
    task automatic run_op(input logic [W-1:0] av, bv, input logic cv, input int stall);
        logic [W:0] exp;
        int n;
        exp = model_add(av, bv, cv);
        n = 0;
        while (!in_ready && n < 200) begin
            @(negedge clk);
            n++;
        end
        check("in_ready_before_accept", in_ready, 1);
        a = av; b = bv; cin = cv; in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        a = W'($urandom); b = W'($urandom); cin = 1'($urandom);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!out_valid && n < 200);
        check("latency", n, LAT);
        check("sum", sum, exp[W-1:0]);
        check("cout", cout, exp[W]);
        check("busy_done", busy, 1);
`ifdef SERIAL_ADD_OVF_EN
        check("ovf", ovf, model_ovf(av, bv, cv));
`endif
        for (int i = 0; i < stall; i++) begin
            in_valid = ~in_valid;
            a = W'($urandom); b = W'($urandom); cin = 1'($urandom);
            @(negedge clk);
            check("stall_out_valid", out_valid, 1);
            check("stall_sum", sum, exp[W-1:0]);
            check("stall_cout", cout, exp[W]);
            check("stall_in_ready", in_ready, 0);
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        @(negedge clk);
        check("post_handoff_out_valid", out_valid, 0);
        check("post_handoff_in_ready", in_ready, 1);
        check("post_handoff_sum_held", sum, exp[W-1:0]);
    endtask

    initial begin
        logic [W:0] e;
        int         n, seen;
        int         acc_cyc[$];
        logic [W:0] exp_q[$];

        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
        a = '0; b = '0; cin = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check("reset_in_ready", in_ready, 1);
        check("reset_out_valid", out_valid, 0);
        check("reset_busy", busy, 0);
        check("reset_sum", sum, 0);
        check("reset_cout", cout, 0);
`ifdef SERIAL_ADD_OVF_EN
        check("reset_ovf", ovf, 0);
`endif

        // Directed corner cases, then a stalled random operation.
        run_op(8'hFF, 8'h01, 1'b0, 0);
        run_op(8'h5A, 8'hA5, 1'b1, 0);
        run_op(8'h03, 8'h04, 1'b0, 0);
        run_op(W'($urandom), W'($urandom), 1'($urandom), 5);
        for (int i = 0; i < 4; i++)
            run_op(W'($urandom), W'($urandom), 1'($urandom), int'($urandom_range(0, 2)));

        // Reset in cycle 10 of an operation aborts it.
        a = 8'hC3; b = 8'h77; cin = 1'b1; in_valid = 1'b1;
        @(posedge clk);
        #1 in_valid = 1'b0;
        repeat (10) @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check("abort_out_valid", out_valid, 0);
        check("abort_busy", busy, 0);
        check("abort_in_ready", in_ready, 1);
        check("abort_sum", sum, 0);
        seen = 0;
        for (int i = 0; i < 2 * LAT; i++) begin
            if (out_valid) seen++;
            @(negedge clk);
        end
        check("abort_no_late_result", seen, 0);
        run_op(8'h03, 8'h04, 1'b0, 0);

        // Back-to-back with in_valid and out_ready held high.
        in_valid = 1'b1; out_ready = 1'b1;
        a = W'($urandom); b = W'($urandom); cin = 1'($urandom);
        seen = 0; n = 0;
        while (seen < 3 && n < 300) begin
            if (in_ready) begin
                if (acc_cyc.size() < 3) begin
                    acc_cyc.push_back(cyc);
                    exp_q.push_back(model_add(a, b, cin));
                end
            end else begin
                a = W'($urandom); b = W'($urandom); cin = 1'($urandom);
            end
            if (out_valid && exp_q.size() > 0) begin
                e = exp_q.pop_front();
                check("b2b_sum", sum, e[W-1:0]);
                check("b2b_cout", cout, e[W]);
                seen++;
            end
            if (seen < 3) @(negedge clk);
            n++;
        end
        in_valid = 1'b0;
        check("b2b_results", seen, 3);
        check("b2b_accepts", acc_cyc.size(), 3);
        if (acc_cyc.size() == 3) begin
            check("b2b_gap1", acc_cyc[1] - acc_cyc[0], LAT + 1);
            check("b2b_gap2", acc_cyc[2] - acc_cyc[0], 2 * (LAT + 1));
        end
        @(posedge clk);
        #1 out_ready = 1'b0;
        @(negedge clk);
        check("b2b_idle", in_ready, 1);

`ifdef SERIAL_ADD_OVF_EN
        run_op(8'h7F, 8'h01, 1'b0, 0);
        check("ovf_7f_sum", sum, 8'h80);
        check("ovf_7f_flag", ovf, 1);
        run_op(8'h80, 8'h80, 1'b0, 0);
        check("ovf_80_sum", sum, 8'h00);
        check("ovf_80_flag", ovf, 1);
        run_op(8'h01, 8'h01, 1'b0, 0);
        check("ovf_01_flag", ovf, 0);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
